tx_ppdu_scheduler: RTL and testbench

Frame-level sequencer for the 802.11a OFDM transmit chain at 2x oversampling (160 samples per symbol: 32 CP + 128).
- On a start pulse it plays the training preamble (STF+LTF) from an external sample ROM.
- It then requests the SIGNAL symbol and N DATA symbols from the encode/IFFT/cyclic-prefix path and forwards their time-domain samples.
- It merges everything into one ordered sample stream for the DAC interface.
- It detects mid-symbol underrun and missing symbols, and aborts the frame on either.

---
 rtl/tx_ppdu_scheduler.sv | 158 +++++++++++++++
 tb/tb_tx_ppdu_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ppdu_scheduler.sv
// 802.11a transmit frame sequencer: plays the preamble from ROM, then forwards the
// SIGNAL and DATA symbols from the encoder/IFFT path as one ordered sample stream.
module tx_ppdu_scheduler #(
  parameter int SYM_LEN = 160,
  parameter int PRE_LEN = 640,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_Modulation,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [15:0]       tx_n_sym,
  output logic              tx_busy,
  output logic              sig_sym_req,
  output logic              data_sym_req,
  input  logic              sym_in_valid,
  input  logic [15:0]       sym_in_re,
  input  logic [15:0]       sym_in_im,
  output logic              preamble_rd_en,
  output logic [ADDR_W-1:0] preamble_rd_addr,
  input  logic [15:0]       preamble_re,
  input  logic [15:0]       preamble_im,
  output logic              tx_out_valid,
  output logic [15:0]       tx_out_re,
  output logic [15:0]       tx_out_im,
  output logic              tx_done,
  output logic [1:0]        tx_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_SIG, S_WAIT_DATA, S_SYM, S_FIN
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_sig_req;
  logic              r_data_req;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_out_valid;
  logic              r_out_pre;
  logic [15:0]       r_out_re;
  logic [15:0]       r_out_im;
  logic              r_done;
  logic [1:0]        r_err;
  logic [15:0]       r_rem_sym;
  logic [7:0]        r_sym_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic        w_fwd;
  logic [15:0] w_rem_after_first;

  assign w_fwd = sym_in_valid &&
                 (r_state == S_WAIT_SIG || r_state == S_WAIT_DATA || r_state == S_SYM);
  // The SIGNAL symbol does not consume a DATA count; each DATA symbol does on its first sample.
  assign w_rem_after_first = (r_state == S_WAIT_SIG) ? r_rem_sym : r_rem_sym - 16'd1;

  // NOTE: all state updates below are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk_Modulation) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_sig_req   <= 1'b0;
      r_data_req  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_pre   <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_rem_sym   <= '0;
      r_sym_cnt   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_sig_req   <= 1'b0;
      r_data_req  <= 1'b0;
      r_done      <= 1'b0;
      r_out_pre   <= 1'b0;
      r_out_valid <= w_fwd;
      r_out_re    <= w_fwd ? sym_in_re : 16'd0;
      r_out_im    <= w_fwd ? sym_in_im : 16'd0;
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_rem_sym <= tx_n_sym;
            r_err     <= '0;
            r_busy    <= 1'b1;
            r_sig_req <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= S_PRE;
          end
        end
        S_PRE: begin
          // ROM data is registered inside the ROM, so the mux below forwards it directly.
          r_out_valid <= 1'b1;
          r_out_pre   <= 1'b1;
          if (r_rd_addr == ADDR_W'(PRE_LEN - 1)) begin
            r_rd_en    <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT_SIG;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_WAIT_SIG, S_WAIT_DATA: begin
          if (sym_in_valid) begin
            r_sym_cnt  <= 8'd1;
            r_rem_sym  <= w_rem_after_first;
            r_data_req <= (w_rem_after_first != 16'd0);
            r_state    <= S_SYM;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT)) begin
            r_err[1] <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_SYM: begin
          if (!sym_in_valid) begin
            r_err[0] <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_sym_cnt == 8'(SYM_LEN - 1)) begin
            r_sym_cnt  <= '0;
            r_wait_cnt <= '0;
            r_state    <= (r_rem_sym != 16'd0) ? S_WAIT_DATA : S_FIN;
          end else begin
            r_sym_cnt <= r_sym_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_busy          = r_busy;
  assign sig_sym_req      = r_sig_req;
  assign data_sym_req     = r_data_req;
  assign preamble_rd_en   = r_rd_en;
  assign preamble_rd_addr = r_rd_addr;
  assign tx_out_valid     = r_out_valid;
  assign tx_out_re        = r_out_pre ? preamble_re : r_out_re;
  assign tx_out_im        = r_out_pre ? preamble_im : r_out_im;
  assign tx_done          = r_done;
  assign tx_err           = r_err;

endmodule

// File: tb/tb_tx_ppdu_scheduler.sv
// Randomized bench for tx_ppdu_scheduler: a ROM model, an encoder model driven by the
// request pulses, and an expected-sample queue built from the frame rules.
module tb_tx_ppdu_scheduler;

  localparam int SYM_LEN = 160;
  localparam int PRE_LEN = 640;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1023;

  logic              clk_Modulation = 1'b0;
  logic              reset          = 1'b1;
  logic              tx_start       = 1'b0;
  logic [15:0]       tx_n_sym       = '0;
  logic              sym_in_valid   = 1'b0;
  logic [15:0]       sym_in_re      = '0;
  logic [15:0]       sym_in_im      = '0;
  logic [15:0]       preamble_re    = '0;
  logic [15:0]       preamble_im    = '0;
  logic              tx_busy, sig_sym_req, data_sym_req, preamble_rd_en;
  logic [ADDR_W-1:0] preamble_rd_addr;
  logic              tx_out_valid, tx_done;
  logic [15:0]       tx_out_re, tx_out_im;
  logic [1:0]        tx_err;

  tx_ppdu_scheduler #(
    .SYM_LEN(SYM_LEN), .PRE_LEN(PRE_LEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_Modulation  (clk_Modulation),
    .reset           (reset),
    .tx_start        (tx_start),
    .tx_n_sym        (tx_n_sym),
    .tx_busy         (tx_busy),
    .sig_sym_req     (sig_sym_req),
    .data_sym_req    (data_sym_req),
    .sym_in_valid    (sym_in_valid),
    .sym_in_re       (sym_in_re),
    .sym_in_im       (sym_in_im),
    .preamble_rd_en  (preamble_rd_en),
    .preamble_rd_addr(preamble_rd_addr),
    .preamble_re     (preamble_re),
    .preamble_im     (preamble_im),
    .tx_out_valid    (tx_out_valid),
    .tx_out_re       (tx_out_re),
    .tx_out_im       (tx_out_im),
    .tx_done         (tx_done),
    .tx_err          (tx_err)
  );

  always #5 clk_Modulation = ~clk_Modulation;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rom_re(input int a);
    return 16'(a * 97 + 13);
  endfunction

  function automatic logic [15:0] rom_im(input int a);
    return 16'(32'hA5A5 ^ (a * 29));
  endfunction

  // Synchronous ROM: data for the address presented with rd_en appears the next cycle.
  always @(posedge clk_Modulation) begin
    if (preamble_rd_en) begin
      preamble_re <= rom_re(int'(preamble_rd_addr));
      preamble_im <= rom_im(int'(preamble_rd_addr));
    end
  end

  int cyc = 0;
  always @(posedge clk_Modulation) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          req_cyc_q[$];
  bit          req_sig_q[$];
  int n_sig, n_data, n_done, n_valid, n_rd;
  int last_valid_cyc, done_cyc, sym0_cyc;

  always @(negedge clk_Modulation) begin
    if (sig_sym_req) begin
      n_sig++;
      req_cyc_q.push_back(cyc);
      req_sig_q.push_back(1'b1);
    end
    if (data_sym_req) begin
      n_data++;
      req_cyc_q.push_back(cyc);
      req_sig_q.push_back(1'b0);
    end
    if (preamble_rd_en) n_rd++;
    if (tx_done) begin
      n_done++;
      done_cyc = cyc;
      check("busy_with_done", 64'(tx_busy), 64'd0);
    end
    if (tx_out_valid) begin
      if (n_valid == PRE_LEN) sym0_cyc = cyc;
      n_valid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) check("extra_sample", 64'(exp_q.size()), 64'd1);
      else                   check("sample", 64'({tx_out_re, tx_out_im}), 64'(exp_q.pop_front()));
    end else begin
      check("idle_zero", 64'({tx_out_re, tx_out_im}), 64'd0);
    end
  end

  // Encoder model: answers each request in order after enc_delay cycles, never before
  // enc_earliest, optionally dropping DATA requests or stopping mid-symbol.
  int enc_delay = 0, enc_earliest = 0, sym_idx = 0;
  int drop_sym = -1, drop_smp = -1, drop_cyc = 0;
  bit enc_mute_data = 1'b0, enc_halt = 1'b1;

  task automatic send_symbol();
    logic [31:0] v;
    for (int i = 0; i < SYM_LEN; i++) begin
      if (i > 0) @(negedge clk_Modulation);
      if (sym_idx == drop_sym && i == drop_smp) begin
        sym_in_valid = 1'b0;
        sym_in_re    = '0;
        sym_in_im    = '0;
        drop_cyc     = cyc;
        enc_halt     = 1'b1;
        break;
      end
      v = $urandom;
      sym_in_valid = 1'b1;
      sym_in_re    = v[31:16];
      sym_in_im    = v[15:0];
      exp_q.push_back(v);
    end
    sym_idx++;
  endtask

  initial begin
    forever begin
      @(negedge clk_Modulation);
      sym_in_valid = 1'b0;
      sym_in_re    = '0;
      sym_in_im    = '0;
      if (!enc_halt && req_cyc_q.size() > 0) begin
        if (!req_sig_q[0] && enc_mute_data) begin
          void'(req_cyc_q.pop_front());
          void'(req_sig_q.pop_front());
        end else if (cyc >= req_cyc_q[0] + enc_delay && cyc >= enc_earliest) begin
          void'(req_cyc_q.pop_front());
          void'(req_sig_q.pop_front());
          send_symbol();
        end
      end
    end
  end

  task automatic start_frame(input int n, input int delay, input int extra);
    @(negedge clk_Modulation);
    req_cyc_q.delete();
    req_sig_q.delete();
    n_sig = 0; n_data = 0; n_done = 0; n_valid = 0; n_rd = 0;
    sym_idx      = 0;
    enc_halt     = 1'b0;
    enc_delay    = delay;
    enc_earliest = cyc + PRE_LEN + 1 + extra;
    for (int a = 0; a < PRE_LEN; a++) exp_q.push_back({rom_re(a), rom_im(a)});
    tx_n_sym = 16'(n);
    tx_start = 1'b1;
    @(negedge clk_Modulation);
    tx_start = 1'b0;
  endtask

  task automatic wait_end(output int fall_cyc);
    int i;
    i = 0;
    while (tx_busy && i < 8000) begin
      @(negedge clk_Modulation);
      i++;
    end
    check("frame_end", 64'(tx_busy), 64'd0);
    fall_cyc = cyc;
    repeat (3) @(negedge clk_Modulation);
  endtask

  task automatic check_good_frame(input int n, input int fall, input bit b2b);
    check("n_sig", n_sig, 1);
    check("n_data", n_data, n);
    check("n_done", n_done, 1);
    check("err_clean", 64'(tx_err), 64'd0);
    check("n_rd", n_rd, PRE_LEN);
    check("n_valid", n_valid, PRE_LEN + SYM_LEN * (n + 1));
    check("exp_drained", exp_q.size(), 0);
    check("done_after_last", done_cyc, last_valid_cyc + 1);
    check("busy_fall_at_done", fall, done_cyc);
    if (b2b) check("contiguous", last_valid_cyc - sym0_cyc + 1, SYM_LEN * (n + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 64'({tx_busy, sig_sym_req, data_sym_req, preamble_rd_en, preamble_rd_addr,
                    tx_out_valid, tx_out_re, tx_out_im, tx_done, tx_err}), 64'd0);
  endtask

  task automatic good_frame(input int n, input int delay, input int extra, input bit b2b);
    int fall;
    start_frame(n, delay, extra);
    wait_end(fall);
    check_good_frame(n, fall, b2b);
  endtask

  initial begin
    int fall;
    repeat (3) @(negedge clk_Modulation);
    check_idle_outputs("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk_Modulation);

    good_frame(2, 50, 0, 1'b0);
    good_frame(0, 50, 0, 1'b0);
    good_frame(3, 0, 0, 1'b1);

    // Underrun at sample 100 of the first DATA symbol.
    drop_sym = 1;
    drop_smp = 100;
    start_frame(2, 30, 5);
    wait_end(fall);
    drop_sym = -1;
    check("underrun_err", 64'(tx_err), 64'd1);
    check("underrun_no_done", n_done, 0);
    check("underrun_fall", fall, drop_cyc + 1);
    check("underrun_n_valid", n_valid, PRE_LEN + SYM_LEN + 100);
    check("underrun_drained", exp_q.size(), 0);
    repeat (5) @(negedge clk_Modulation);
    check("underrun_err_sticky", 64'(tx_err), 64'd1);
    good_frame(1, 20, 0, 1'b0);

    // Encoder ignores DATA requests.
    enc_mute_data = 1'b1;
    start_frame(1, 10, 0);
    wait_end(fall);
    enc_mute_data = 1'b0;
    check("timeout_err", 64'(tx_err), 64'd2);
    check("timeout_no_done", n_done, 0);
    check("timeout_n_data", n_data, 1);
    check("timeout_n_valid", n_valid, PRE_LEN + SYM_LEN);
    check("timeout_len", fall - last_valid_cyc, TIMEOUT + 1);
    check("timeout_out_idle", 64'(tx_out_valid), 64'd0);

    // Second start during PRE is ignored; reset at preamble address 300.
    start_frame(1, 20, 0);
    for (int i = 0; i < 2000 && preamble_rd_addr != 10'd100; i++) @(negedge clk_Modulation);
    tx_start = 1'b1;
    @(negedge clk_Modulation);
    tx_start = 1'b0;
    for (int i = 0; i < 2000 && preamble_rd_addr != 10'd300; i++) @(negedge clk_Modulation);
    check("reach_addr300", 64'(preamble_rd_addr), 64'd300);
    reset    = 1'b1;
    enc_halt = 1'b1;
    @(negedge clk_Modulation);
    reset = 1'b0;
    check_idle_outputs("mid_frame_reset");
    check("restart_ignored", n_sig, 1);
    exp_q.delete();
    repeat (3) @(negedge clk_Modulation);
    check("reset_no_done", n_done, 0);
    good_frame(1, 20, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      good_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 60)),
                 int'($urandom_range(0, 40)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
